// File: rtl/regb_fifo_tx.sv
// Drain-side serializer for the register-based FIFO. Pops one word at a time and
// sends it as an asynchronous frame: start bit (0), WIDTH data bits LSB first, stop bit (1).
module regb_fifo_tx #(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic [WIDTH-1:0] rdata,
  input  logic             empty,
  output logic             shift_out,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] ClkLast = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BitLast = BW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e           state;
  logic [CW-1:0]    clk_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] sreg;

  logic             clk_last;
  logic             bit_last;
  logic             pop;
  logic [WIDTH-1:0] sreg_shr;

  assign clk_last   = (clk_cnt == ClkLast);
  assign bit_last   = (bit_cnt == BitLast);
  assign frame_done = (state == StStop) && clk_last;
  // Pop from idle, or in the final stop-bit cycle so back-to-back frames have no gap.
  assign pop        = en && !empty && !res && ((state == StIdle) || frame_done);
  assign shift_out  = pop;
  assign busy       = (state != StIdle);
  assign sreg_shr   = sreg >> 1;

  // Frame sequencer; tx is registered from the state being entered so it lines up with it.
  always_ff @(posedge clk) begin
    if (res) begin
      state   <= StIdle;
      tx      <= 1'b1;
      clk_cnt <= '0;
      bit_cnt <= '0;
      sreg    <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (pop) begin
            sreg    <= rdata;
            clk_cnt <= '0;
            bit_cnt <= '0;
            tx      <= 1'b0;
            state   <= StStart;
          end
        end
        StStart: begin
          if (clk_last) begin
            clk_cnt <= '0;
            tx      <= sreg[0];
            state   <= StData;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        StData: begin
          if (clk_last) begin
            clk_cnt <= '0;
            sreg    <= sreg_shr;
            if (bit_last) begin
              bit_cnt <= '0;
              tx      <= 1'b1;
              state   <= StStop;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              tx      <= sreg_shr[0];
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        StStop: begin
          if (clk_last) begin
            clk_cnt <= '0;
            if (pop) begin
              sreg    <= rdata;
              bit_cnt <= '0;
              tx      <= 1'b0;
              state   <= StStart;
            end else begin
              tx      <= 1'b1;
              state   <= StIdle;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        default: begin
          state <= StIdle;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regb_fifo_tx.sv
// Bench for regb_fifo_tx: instance A (WIDTH=4, CLKS_PER_BIT=4), instance B (WIDTH=8,
// CLKS_PER_BIT=1). Each has a queue acting as the FIFO and a frame-timeline model.
module tb_regb_fifo_tx;

  logic       clk;
  logic       res;
  logic       en;
  logic       empty_a, empty_b;
  logic [3:0] rdata_a;
  logic [7:0] rdata_b;
  logic       so_a, tx_a, busy_a, fd_a;
  logic       so_b, tx_b, busy_b, fd_b;

  regb_fifo_tx #(.WIDTH(4), .CLKS_PER_BIT(4)) u_dut_a (
    .clk(clk), .res(res), .en(en), .rdata(rdata_a), .empty(empty_a),
    .shift_out(so_a), .tx(tx_a), .busy(busy_a), .frame_done(fd_a)
  );

  regb_fifo_tx #(.WIDTH(8), .CLKS_PER_BIT(1)) u_dut_b (
    .clk(clk), .res(res), .en(en), .rdata(rdata_b), .empty(empty_b),
    .shift_out(so_b), .tx(tx_b), .busy(busy_b), .frame_done(fd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] qa[$];
  logic [7:0] qb[$];

  int n_chk = 0;
  int n_err = 0;

  // Model: a frame is a timeline of (W+2)*C cycles indexed by t, starting the cycle after pop.
  int         wp[2] = '{4, 8};
  int         cp[2] = '{4, 1};
  bit         act[2] = '{0, 0};
  int         t[2] = '{0, 0};
  logic [7:0] word[2];

  bit         chk_on = 0;
  bit         rec = 0;
  logic [31:0] tr_a, tr_b;
  int cnt_so_a, cnt_fd_a, cnt_busy_a, cnt_so_b, cnt_fd_b, run_a, max_run_a;
  logic s_tx_a, s_busy_a, s_so_a, s_so_b;

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int flen(input int i);
    return (wp[i] + 2) * cp[i];
  endfunction

  function automatic int exp_tx(input int i);
    if (!act[i]) return 1;
    if (t[i] < cp[i]) return 0;
    if (t[i] < (wp[i] + 1) * cp[i]) return int'(word[i][(t[i] - cp[i]) / cp[i]]);
    return 1;
  endfunction

  function automatic int exp_pop(input int i, input logic e);
    return int'(!res && en && !e && (!act[i] || t[i] == flen(i) - 1));
  endfunction

  task automatic step(input int i, input logic e, input logic [7:0] rd);
    if (res) begin
      act[i] = 0;
    end else if (exp_pop(i, e) != 0) begin
      act[i] = 1; t[i] = 0; word[i] = rd;
    end else if (act[i]) begin
      if (t[i] == flen(i) - 1) act[i] = 0;
      else t[i]++;
    end
  endtask

  task automatic clr();
    cnt_so_a = 0; cnt_fd_a = 0; cnt_busy_a = 0; cnt_so_b = 0; cnt_fd_b = 0;
    run_a = 0; max_run_a = 0;
  endtask

  // One clock cycle: present FIFO head, compare against the model, advance, pop the queues.
  task automatic cycle();
    bit pa, pb;
    empty_a = (qa.size() == 0);
    rdata_a = empty_a ? 4'h0 : qa[0];
    empty_b = (qb.size() == 0);
    rdata_b = empty_b ? 8'h00 : qb[0];
    #1;
    s_tx_a = tx_a; s_busy_a = busy_a; s_so_a = so_a; s_so_b = so_b;
    if (chk_on) begin
      chk("a_tx", int'(tx_a), exp_tx(0));
      chk("a_busy", int'(busy_a), int'(act[0]));
      chk("a_frame_done", int'(fd_a), int'(act[0] && t[0] == flen(0) - 1));
      chk("a_shift_out", int'(so_a), exp_pop(0, empty_a));
      chk("b_tx", int'(tx_b), exp_tx(1));
      chk("b_busy", int'(busy_b), int'(act[1]));
      chk("b_frame_done", int'(fd_b), int'(act[1] && t[1] == flen(1) - 1));
      chk("b_shift_out", int'(so_b), exp_pop(1, empty_b));
    end
    if (so_a) cnt_so_a++;
    if (fd_a) cnt_fd_a++;
    if (so_b) cnt_so_b++;
    if (fd_b) cnt_fd_b++;
    if (busy_a) begin
      cnt_busy_a++; run_a++;
      if (run_a > max_run_a) max_run_a = run_a;
    end else begin
      run_a = 0;
    end
    if (rec) begin
      tr_a = {tr_a[30:0], tx_a};
      tr_b = {tr_b[30:0], tx_b};
    end
    step(0, empty_a, {4'h0, rdata_a});
    step(1, empty_b, rdata_b);
    pa = so_a;
    pb = so_b;
    @(posedge clk);
    if (pa && qa.size() > 0) void'(qa.pop_front());
    if (pb && qb.size() > 0) void'(qb.pop_front());
    @(negedge clk);
  endtask

  initial begin
    res = 1'b1; en = 1'b1;
    empty_a = 1'b1; empty_b = 1'b1; rdata_a = '0; rdata_b = '0;
    tr_a = '0; tr_b = '0;
    clr();
    @(negedge clk);
    cycle();
    chk_on = 1;
    cycle();
    res = 1'b0;

    // Reset state and long idle with an empty FIFO
    cycle();
    chk("rst_tx", int'(s_tx_a), 1);
    chk("rst_busy", int'(s_busy_a), 0);
    clr();
    repeat (50) cycle();
    chk("idle_shift_out", cnt_so_a, 0);
    chk("idle_busy", cnt_busy_a, 0);

    // Single word 4'hA
    clr();
    qa.push_back(4'hA);
    cycle();
    chk("a_pop_same_cycle", int'(s_so_a), 1);
    tr_a = '0; rec = 1;
    repeat (24) cycle();
    rec = 0;
    chk("frame_A_trace", int'(tr_a[23:0]), 24'h00F0FF);
    chk("frame_A_pops", cnt_so_a, 1);
    chk("frame_A_done", cnt_fd_a, 1);
    chk("frame_A_empty", qa.size(), 0);
    cycle();
    chk("frame_A_idle_after", int'(s_busy_a), 0);

    // Back-to-back 3, C, F
    repeat (3) cycle();
    clr();
    qa.push_back(4'h3); qa.push_back(4'hC); qa.push_back(4'hF);
    repeat (80) cycle();
    chk("b2b_pops", cnt_so_a, 3);
    chk("b2b_done", cnt_fd_a, 3);
    chk("b2b_busy_run", max_run_a, 72);
    chk("b2b_empty", qa.size(), 0);

    // Enable dropped mid-frame
    clr();
    qa.push_back(4'h5);
    cycle();
    repeat (5) cycle();
    en = 1'b0;
    qa.push_back(4'h6);
    repeat (30) cycle();
    chk("en_low_fifo_kept", qa.size(), 1);
    chk("en_low_pops", cnt_so_a, 1);
    chk("en_low_done", cnt_fd_a, 1);
    en = 1'b1;
    repeat (30) cycle();
    chk("en_high_fifo_drained", qa.size(), 0);
    chk("en_high_pops", cnt_so_a, 2);
    chk("en_high_done", cnt_fd_a, 2);

    // Reset in the middle of DATA, then the queued word goes out cleanly
    qa.push_back(4'h9); qa.push_back(4'h2);
    cycle();
    repeat (10) cycle();
    res = 1'b1;
    cycle();
    chk("mid_rst_no_pop", int'(s_so_a), 0);
    res = 1'b0;
    cycle();
    chk("post_rst_tx", int'(s_tx_a), 1);
    chk("post_rst_busy", int'(s_busy_a), 0);
    chk("post_rst_pop", int'(s_so_a), 1);
    clr();
    tr_a = '0; rec = 1;
    repeat (24) cycle();
    rec = 0;
    chk("frame_2_trace", int'(tr_a[23:0]), 24'h00F00F);
    chk("frame_2_done", cnt_fd_a, 1);
    chk("frame_2_empty", qa.size(), 0);

    // WIDTH=8, one clock per bit: 8'h81
    repeat (3) cycle();
    clr();
    qb.push_back(8'h81);
    cycle();
    chk("b_pop", int'(s_so_b), 1);
    tr_b = '0; rec = 1;
    repeat (10) cycle();
    rec = 0;
    chk("frame_81_trace", int'(tr_b[9:0]), 10'h103);
    chk("frame_81_done", cnt_fd_b, 1);
    repeat (5) cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
